// File: rtl/button_pkg.sv
// button_pkg: debouncer FSM states and default timing for a 12 MHz board clock.
package button_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PRESS_WAIT, ST_PRESSED, ST_RELEASE_WAIT} state_t;
  localparam int unsigned CLK_HZ = 12_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 240_000;
  localparam int unsigned LONG_CYCLES_DEF = 12_000_000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronised, debounced push-button with press/release/long events and press counter.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  output logic             level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);
  logic pin_s, act, counting;
  state_t state_q, state_d;
  logic [DW-1:0] db_q, db_d;
  logic [HW-1:0] hold_q, hold_d;
  logic level_q, level_d, press_q, press_d, rel_q, rel_d, long_q, long_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(button),
    .q_o(pin_s)
  );
  assign act = pin_s ^ ACTIVE_LOW;
  assign counting = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (act) begin
        state_d = ST_PRESS_WAIT;
        db_d    = DW'(1);
      end
      ST_PRESS_WAIT: if (!act) begin
        state_d = ST_IDLE;
        db_d    = '0;
      end else if (db_q == DB_MAX) begin
        state_d = ST_PRESSED;
        db_d    = '0;
        level_d = 1'b1;
        press_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end else db_d = db_q + 1'b1;
      ST_PRESSED: if (!act) begin
        state_d = ST_RELEASE_WAIT;
        db_d    = DW'(1);
      end
      ST_RELEASE_WAIT: if (act) begin
        state_d = ST_PRESSED;
        db_d    = '0;
      end else if (db_q == DB_MAX) begin
        state_d = ST_IDLE;
        db_d    = '0;
        level_d = 1'b0;
        rel_d   = 1'b1;
      end else db_d = db_q + 1'b1;
      default: state_d = ST_IDLE;
    endcase
    // Hold time keeps running through release bounces; an accepted release beats a same-edge long event.
    hold_d = (press_d || rel_d) ? '0 : (counting && hold_q != HOLD_MAX) ? hold_q + 1'b1 : hold_q;
    long_d = counting && !rel_d && (hold_q == HOLD_PRE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      db_q    <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      cnt_q   <= cnt_d;
    end
  end
  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign press_count   = cnt_q;
endmodule
